gps_iq_collector: RTL and testbench

Serial-side reader for the GPS correlator channels' IQ accumulator shift registers. At each channel's code epoch it arbitrates among channels, drives that channel's `shift` strobe, deserializes its MSB-first `sout` stream into integrator words, and pushes tagged words into a first-word-fall-through FIFO. The embedded CPU drains the FIFO instead of bit-banging each channel. It sits between the per-channel DEMOD instances and the CPU register interface.

---
 rtl/gps_iq_collector.sv | 142 ++++++++++++++
 tb/tb_gps_iq_collector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_iq_collector.sv
// Serial-side reader for the GPS correlator IQ shift registers: round-robin grant at code epoch,
// MSB-first deserialization, tagged words into a FWFT FIFO. GPS_IQ_E1B_EN selects 12 words/frame, else 6.
module gps_iq_collector #(
  parameter int NCHAN      = 12,
  parameter int INTEG_BITS = 18,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NCHAN-1:0]                chan_epoch,
  input  logic [NCHAN-1:0]                chan_sout,
  output logic [NCHAN-1:0]                chan_shift,
  input  logic                            rd_en,
  output logic                            rd_valid,
  output logic [8+INTEG_BITS-1:0]         rd_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [NCHAN-1:0]                ovr,
  input  logic                            ovr_clr,
  output logic                            busy
);

`ifdef GPS_IQ_E1B_EN
  localparam int NWORDS = 12;
`else
  localparam int NWORDS = 6;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(INTEG_BITS);
  localparam int DW = 8 + INTEG_BITS;

  // state | meaning
  // IDLE  | waiting for a pending channel; grants round-robin after the last one served
  // SHIFT | streaming the selected channel's frame into the FIFO
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_sel, r_last, r_widx, w_gnt_idx;
  logic [BW-1:0]         r_bitcnt;
  logic [INTEG_BITS-1:0] r_sreg, w_word;
  logic [NCHAN-1:0]      r_pending, r_ovr, r_chan_shift, w_shift_nxt;
  logic [NCHAN-1:0]      w_sel_oh, w_gnt_oh, w_ovr_set;
  logic [DW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  w_gnt_valid, w_grant, w_sout, w_shifting, w_abort;
  logic                  w_last_bit, w_push, w_pop, w_frame_done, w_room;

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      if (!w_gnt_valid && r_pending[(int'(r_last) + k) % NCHAN]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = 4'((int'(r_last) + k) % NCHAN);
      end
    end
  end

  assign w_sout       = chan_sout[r_sel];
  assign w_sel_oh     = NCHAN'(1) << r_sel;
  assign w_gnt_oh     = NCHAN'(1) << w_gnt_idx;
  assign w_shifting   = |r_chan_shift;
  // A reload on the active channel wins over the shift it sees in the same cycle
  assign w_abort      = (r_state == ST_SHIFT) && chan_epoch[r_sel];
  assign w_last_bit   = (r_bitcnt == BW'(INTEG_BITS - 1));
  assign w_word       = {r_sreg[INTEG_BITS-2:0], w_sout};
  assign w_push       = w_shifting && w_last_bit && !w_abort;
  assign w_pop        = rd_en && (r_count != '0);
  assign w_frame_done = w_push && (r_widx == 4'(NWORDS - 1));
  assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
  assign w_room       = (w_count_nxt != CW'(FIFO_DEPTH));
  assign w_ovr_set    = (chan_epoch & r_pending) | (w_abort ? w_sel_oh : '0);

  // chan_shift is a flop, so the stall decision looks at next-cycle occupancy
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_shift_nxt = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = ST_SHIFT;
          w_grant     = 1'b1;
          if (w_room) w_shift_nxt = w_gnt_oh;
        end
      end
      ST_SHIFT: begin
        if (w_abort || w_frame_done) w_state_nxt = ST_IDLE;
        else if (w_room)             w_shift_nxt = w_sel_oh;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_last       <= 4'(NCHAN - 1);
      r_widx       <= '0;
      r_bitcnt     <= '0;
      r_sreg       <= '0;
      r_pending    <= '0;
      r_ovr        <= '0;
      r_chan_shift <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_chan_shift <= w_shift_nxt;
      r_pending    <= (r_pending & ~(w_grant ? w_gnt_oh : '0)) | chan_epoch;
      r_ovr        <= (ovr_clr ? '0 : r_ovr) | w_ovr_set;
      r_count      <= w_count_nxt;
      if (w_grant) begin
        r_sel    <= w_gnt_idx;
        r_last   <= w_gnt_idx;
        r_bitcnt <= '0;
        r_widx   <= '0;
      end else if (w_shifting && !w_abort) begin
        r_sreg   <= w_word;
        r_bitcnt <= w_last_bit ? '0 : r_bitcnt + BW'(1);
        if (w_last_bit) r_widx <= r_widx + 4'd1;
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_sel, r_widx, w_word};
  end

  assign chan_shift = r_chan_shift;
  assign rd_valid   = (r_count != '0);
  assign rd_data    = rd_valid ? r_mem[r_rptr] : '0;
  assign fifo_count = r_count;
  assign ovr        = r_ovr;
  assign busy       = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_gps_iq_collector.sv
// Bench for gps_iq_collector: behavioural channel shift registers plus an expected-word queue per scenario.
module tb_gps_iq_collector;
  localparam int NCH = 12;
  localparam int IB  = 18;
  localparam int FD  = 16;
  localparam int DW  = IB + 8;
  localparam int CW  = $clog2(FD) + 1;
`ifdef GPS_IQ_E1B_EN
  localparam int NW = 12;
`else
  localparam int NW = 6;
`endif
  localparam int FB = NW * IB;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] chan_epoch, chan_sout, chan_shift, ovr;
  logic           rd_en, rd_valid, ovr_clr, busy;
  logic [DW-1:0]  rd_data;
  logic [CW-1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic [IB-1:0] frame [NCH][NW];
  logic [FB-1:0] ch_sr [NCH];
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  gps_iq_collector #(.NCHAN(NCH), .INTEG_BITS(IB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .chan_epoch(chan_epoch), .chan_sout(chan_sout),
    .chan_shift(chan_shift), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_count(fifo_count), .ovr(ovr), .ovr_clr(ovr_clr), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [FB-1:0] pack(input int c);
    logic [FB-1:0] v;
    v = '0;
    for (int w = 0; w < NW; w++) v = (v << IB) | FB'(frame[c][w]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] bit_of(input int c);
    return NCH'(1) << c;
  endfunction

  function automatic logic [DW-1:0] tag(input int c, input int w, input logic [IB-1:0] d);
    return {4'(c), 4'(w), d};
  endfunction

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Channel model: load on epoch (priority), shift left on strobe, MSB out
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (chan_epoch[c])      ch_sr[c] <= pack(c);
      else if (chan_shift[c]) ch_sr[c] <= ch_sr[c] << 1;
    end
  end

  always_comb begin
    chan_sout = '0;
    for (int c = 0; c < NCH; c++) chan_sout[c] = ch_sr[c][FB-1];
  end

  always @(negedge clk) if (rst_n && rd_en && rd_valid) got_q.push_back(rd_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] m);
    chan_epoch = m;
    tick();
    chan_epoch = '0;
  endtask

  task automatic rand_frame(input int c);
    for (int w = 0; w < NW; w++) frame[c][w] = IB'($urandom);
  endtask

  task automatic expect_frame(input int c, input int nwords);
    for (int w = 0; w < nwords; w++) exp_q.push_back(tag(c, w, frame[c][w]));
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && chan_shift == '0 && !(rd_en && rd_valid)) q++;
      else q = 0;
      if (q >= 3) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; chan_epoch = '0; rd_en = 1'b0; ovr_clr = 1'b0;
    #12;
    checks++; if (chan_shift !== '0) begin errors++; $display("FAIL reset_shift got %h exp 0", chan_shift); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL reset_ovr got %h exp 0", ovr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    bit ok;
    got_q.delete(); exp_q.delete();
    rd_en = 1'b0;
    for (int w = 0; w < NW; w++) frame[3][w] = IB'(w + 1);
    pulse(bit_of(3));
    checks++; if (chan_shift !== '0) begin errors++; $display("FAIL single_t1 got %h exp 0", chan_shift); end
    tick();
    checks++; if (chan_shift !== bit_of(3)) begin errors++; $display("FAIL single_t2 got %h exp %h", chan_shift, bit_of(3)); end
    n = 0;
    while (chan_shift === bit_of(3) && n < 2 * FB) begin
      n++;
      tick();
    end
    checks++; if (n != FB) begin errors++; $display("FAIL single_len got %0d exp %0d", n, FB); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy); end
    checks++; if (fifo_count !== CW'(NW)) begin errors++; $display("FAIL single_count got %0d exp %0d", fifo_count, NW); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL single_ovr got %h exp 0", ovr); end
    checks++; if (rd_data !== tag(3, 0, 1)) begin errors++; $display("FAIL single_head got %h exp %h", rd_data, tag(3, 0, 1)); end
    expect_frame(3, NW);
    rd_en = 1'b1;
    wait_quiet(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy exp idle"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_words got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin();
    int starts[$];
    int gaps[$];
    int zeros;
    bit seen, ok;
    logic [NCH-1:0] prev;
    rd_en = 1'b1;
    rand_frame(5);
    pulse(bit_of(5));
    wait_quiet(FB + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_setup got busy exp idle"); end
    got_q.delete(); exp_q.delete();
    rand_frame(0); rand_frame(5); rand_frame(11);
    pulse(bit_of(0) | bit_of(5) | bit_of(11));
    zeros = 0; seen = 1'b0; prev = '0;
    for (int i = 0; i < 3 * (FB + 1) + 20; i++) begin
      if (chan_shift != '0 && prev == '0) begin
        starts.push_back(onehot_idx(chan_shift));
        if (seen) gaps.push_back(zeros);
        seen = 1'b1;
      end
      zeros = (chan_shift == '0) ? zeros + 1 : 0;
      prev = chan_shift;
      tick();
    end
    checks++; if (starts.size() != 3) begin errors++; $display("FAIL rr_frames got %0d exp 3", starts.size()); end
    if (starts.size() == 3) begin
      checks++; if (starts[0] != 11) begin errors++; $display("FAIL rr_first got %0d exp 11", starts[0]); end
      checks++; if (starts[1] != 0) begin errors++; $display("FAIL rr_second got %0d exp 0", starts[1]); end
      checks++; if (starts[2] != 5) begin errors++; $display("FAIL rr_third got %0d exp 5", starts[2]); end
    end
    foreach (gaps[i]) begin
      checks++; if (gaps[i] != 1) begin errors++; $display("FAIL rr_gap%0d got %0d exp 1", i, gaps[i]); end
    end
    expect_frame(11, NW); expect_frame(0, NW); expect_frame(5, NW);
    wait_quiet(200, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rr_words got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit ok;
    got_q.delete(); exp_q.delete();
    rd_en = 1'b0;
    rand_frame(1); rand_frame(2); rand_frame(4);
    pulse(bit_of(1) | bit_of(2) | bit_of(4));
    ok = 1'b0;
    for (int i = 0; i < 3 * FB + 50 && !ok; i++) begin
      if (fifo_count == CW'(FD)) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_fill got %0d exp %0d", fifo_count, FD); end
    repeat (2 * IB) tick();
    checks++; if (chan_shift !== '0) begin errors++; $display("FAIL bp_stall got %h exp 0", chan_shift); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b exp 1", busy); end
    checks++; if (fifo_count !== CW'(FD)) begin errors++; $display("FAIL bp_count got %0d exp %0d", fifo_count, FD); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n = 0;
    for (int i = 0; i < 3 * IB; i++) begin
      if (chan_shift != '0) n++;
      tick();
    end
    checks++; if (n != IB) begin errors++; $display("FAIL bp_one_word got %0d shifts exp %0d", n, IB); end
    checks++; if (fifo_count !== CW'(FD)) begin errors++; $display("FAIL bp_refull got %0d exp %0d", fifo_count, FD); end
    expect_frame(1, NW); expect_frame(2, NW); expect_frame(4, NW);
    rd_en = 1'b1;
    wait_quiet(3 * FB + 200, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_words got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_midframe_reload();
    int n;
    bit ok;
    got_q.delete(); exp_q.delete();
    rd_en = 1'b1;
    rand_frame(7);
    expect_frame(7, 2);
    pulse(bit_of(7));
    n = 0;
    for (int i = 0; i < FB + 20; i++) begin
      if (chan_shift[7]) n++;
      if (n == 2 * IB + 5) break;
      tick();
    end
    checks++; if (n != 2 * IB + 5) begin errors++; $display("FAIL reload_reach got %0d exp %0d", n, 2 * IB + 5); end
    rand_frame(7);
    pulse(bit_of(7));
    checks++; if (ovr !== bit_of(7)) begin errors++; $display("FAIL reload_ovr got %h exp %h", ovr, bit_of(7)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reload_abort got busy %b exp 0", busy); end
    expect_frame(7, NW);
    wait_quiet(FB + 100, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reload_words got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reload_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    checks++; if (ovr !== '0) begin errors++; $display("FAIL ovr_clr got %h exp 0", ovr); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    got_q.delete(); exp_q.delete();
    rd_en = 1'b0;
    rand_frame(9); rand_frame(10);
    pulse(bit_of(9));
    ok = 1'b0;
    for (int i = 0; i < FB && !ok; i++) begin
      if (fifo_count == CW'(3)) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_fill got %0d exp 3", fifo_count); end
    repeat (4) tick();
    pulse(bit_of(10));
    pulse(bit_of(10));
    checks++; if (ovr !== bit_of(10)) begin errors++; $display("FAIL ovr_pending got %h exp %h", ovr, bit_of(10)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (chan_shift !== '0) begin errors++; $display("FAIL arst_shift got %h exp 0", chan_shift); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL arst_data got %h exp 0", rd_data); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL arst_count got %0d exp 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
    checks++; if (ovr !== '0) begin errors++; $display("FAIL arst_ovr got %h exp 0", ovr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0 || fifo_count !== '0) begin errors++; $display("FAIL rst_pending got busy %b count %0d exp 0 0", busy, fifo_count); end
    rd_en = 1'b1;
    rand_frame(2); rand_frame(7);
    pulse(bit_of(2) | bit_of(7));
    tick();
    checks++; if (chan_shift !== bit_of(2)) begin errors++; $display("FAIL rst_rr_first got %h exp %h", chan_shift, bit_of(2)); end
    expect_frame(2, NW); expect_frame(7, NW);
    wait_quiet(2 * FB + 100, ok);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_words got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_word%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_midframe_reload();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
